result_drain: RTL and testbench
===============================

Name: result_drain

Overview:
- Downstream stage of the MAC-array top level; consumes the four accumulator lanes (acc_out_0..3) and their per-lane valid bits.
- Captures each valid lane into a holding register and requantizes ACC_W to W bits (round, arithmetic shift, saturate).
- Serializes results, lowest lane first, through a small FIFO to a valid/ready output port that feeds the result memory writer.

Parameters:
- W, 8: output result width.
- ACC_W, 16: accumulator input width.
- N_MACS, 4: number of lanes; fixed at 4 in this revision.
- FIFO_DEPTH, 8: output FIFO entries; must be a power of 2, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- acc_in_0..acc_in_3  in  ACC_W each, signed  accumulator lanes.
- valid_in  in  N_MACS  per-lane capture strobe.
- cfg_shift  in  $clog2(ACC_W)  requantization right-shift; quasi-static.
- flush  in  1  synchronous clear of all buffered state.
- out_data  out  W, signed  requantized result.
- out_lane  out  2  originating lane index.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accept.
- overflow  out  1  sticky lane-overrun flag.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- busy  out  1  any pending lane or non-empty FIFO.

Behaviour:
- Reset (rst=0, async): pending bits, holding registers, FIFO pointers, fifo_count, overflow and out_valid all go to 0. out_data and out_lane read 0.
- Capture:
  - valid_in[i]=1 latches acc_in_i into hold[i] and sets pending[i].
  - If pending[i] is already 1 and lane i is not being drained this cycle, the new sample is dropped, hold[i] is unchanged and overflow is set.
- Drain arbiter:
  - Each cycle, if any pending bit is set and the FIFO is not full, the lowest-index pending lane is requantized and pushed with its lane index, and its pending bit clears.
  - Exactly one push per cycle at most.
- Simultaneous drain and capture on the same lane: drain uses the old hold value. The new sample is captured, pending stays 1 and overflow is not set.
- Requantization:
  - Computed in ACC_W+1 signed bits: t = acc + (cfg_shift>0 ? 1<<(cfg_shift-1) : 0).
  - r = t >>> cfg_shift.
  - Saturate r to [-(2^(W-1)), 2^(W-1)-1].
- FIFO:
  - First-word-fall-through: out_data and out_lane show the head whenever out_valid=1.
  - Pop on out_valid && out_ready.
  - Push is gated by count<FIFO_DEPTH; there is no pass-through when full, even if popping.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count is updated as +push -pop.
- Latency: valid_in at cycle N, with the FIFO empty and no other pending lane, gives out_valid=1 at cycle N+2.
- Backpressure: while the FIFO is full, pending lanes wait. Further valid_in on a waiting lane raises overflow.
- flush:
  - Clears pending, FIFO contents, fifo_count and overflow on the next edge.
  - Overrides any capture or push in the same cycle.
  - A pop in the same cycle is ignored.
- busy = |pending || (fifo_count != 0).
- Reset asserted mid-operation discards all data immediately. No output is produced until new valid_in arrives.

Optional Feature:
- Macro: RESULT_DRAIN_RELU_EN.
- Defined: adds input relu_en (1 bit). When relu_en=1, negative saturated results are replaced by 0 before the FIFO push.
- Not defined: the port is absent and signed results pass unmodified.

Decomposition:
- Package result_drain_pkg:
  - lane index typedef (2 bits);
  - SAT_MAX/SAT_MIN constants derived from W;
  - requant function (acc, shift) -> W-bit saturated value;
  - FIFO entry struct {lane, data}.
- Sub-module result_fifo: parameterized FWFT synchronous FIFO (width W+2, depth FIFO_DEPTH) with count output. The arbiter, hold registers and requantization stay in result_drain.

Test Plan:
- Latency/rounding: cfg_shift=4, out_ready=1, valid_in=4'b0001, acc_in_0=291 at cycle 0 -> out_valid at cycle 2 with out_data=18, out_lane=0.
- Negative and saturation: cfg_shift=4, all lanes valid at once with acc = {-300, 32767, -32768, 0} -> four pops in lane order 0,1,2,3 with data {-19, 127, -128, 0}, one per cycle.
- Backpressure/full:
  - out_ready=0; send eight single-lane samples -> fifo_count=8;
  - then a lane-0 sample -> held, and a further lane-0 sample -> overflow=1;
  - raise out_ready -> 9 outputs drain in order.
- Same-lane drain+capture: lane 2 pending and being drained while valid_in[2] re-asserts with a new value -> both values emerge in order, overflow=0.
- flush: FIFO holding 3 entries plus 2 pending lanes, pulse flush -> next cycle fifo_count=0, busy=0, overflow=0, out_valid=0.
- ReLU (RESULT_DRAIN_RELU_EN defined, relu_en=1): acc_in_1=-300, cfg_shift=4 -> out_data=0. With relu_en=0 -> out_data=-19.

Source files
------------

// File: rtl/result_drain_pkg.sv
// Shared types and helpers for the result drain stage.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// The widths here are the single source for the requantizer and the FIFO
// entry layout; result_drain's W/ACC_W parameters must match RD_W/RD_ACC_W.
package result_drain_pkg;

    localparam int RD_W       = 8;
    localparam int RD_ACC_W   = 16;
    localparam int RD_N_MACS  = 4;
    localparam int RD_SHIFT_W = $clog2(RD_ACC_W);

    // Saturation bounds of a signed RD_W-bit result.
    localparam int SAT_MAX = (2 ** (RD_W - 1)) - 1;
    localparam int SAT_MIN = -(2 ** (RD_W - 1));

    // The same bounds at the internal requantization width.
    localparam logic signed [RD_ACC_W:0] SAT_MAX_X = (RD_ACC_W + 1)'(SAT_MAX);
    localparam logic signed [RD_ACC_W:0] SAT_MIN_X = (RD_ACC_W + 1)'(SAT_MIN);

    typedef logic [1:0]                 lane_t;
    typedef logic signed [RD_W-1:0]     res_t;
    typedef logic signed [RD_ACC_W-1:0] acc_t;

    typedef struct packed {
        lane_t lane;
        res_t  data;
    } fifo_entry_t;

    // Round-half-up, arithmetic right shift, then saturate to RD_W bits.
    // One guard bit above the accumulator keeps acc + rounding constant
    // from wrapping when acc sits at its positive limit.
    function automatic res_t requant(input acc_t acc,
                                     input logic [RD_SHIFT_W-1:0] shift);
        logic signed [RD_ACC_W:0] rnd;
        logic signed [RD_ACC_W:0] t;
        logic signed [RD_ACC_W:0] r;
        res_t                     q;
        rnd = '0;
        if (shift != '0) begin
            rnd = {{RD_ACC_W{1'b0}}, 1'b1} << (shift - RD_SHIFT_W'(1));
        end
        t = {acc[RD_ACC_W-1], acc} + rnd;
        r = t >>> shift;
        if (r > SAT_MAX_X) begin
            q = res_t'(SAT_MAX);
        end else if (r < SAT_MIN_X) begin
            q = res_t'(SAT_MIN);
        end else begin
            q = res_t'(r);
        end
        return q;
    endfunction

endpackage

// File: rtl/result_drain_if.sv
// Valid/ready result port from the drain stage to the result memory writer.
// Latency: n/a (signal bundle only).
// Backpressure: producer holds out_data/out_lane/out_valid until out_ready.
//
// Signals:
//   out_data  - signed requantized result (W bits)
//   out_lane  - originating lane index
//   out_valid - head of the output queue is valid
//   out_ready - consumer accepts the head this cycle
interface result_drain_if #(
    parameter int W = 8
);
    logic signed [W-1:0] out_data;
    logic [1:0]          out_lane;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output out_data,
        output out_lane,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_lane,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/result_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// Latency: a push is visible at the head on the cycle after the push edge.
// Backpressure: pushes are refused while full (no pass-through on a same-cycle pop).
//
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   i_flush         - synchronous clear; wins over push and pop
//   i_push_vld/dat  - write request and entry
//   i_pop_rdy       - consume the head (ignored when empty)
//   o_head_dat/vld  - head entry (zero when empty) and non-empty flag
//   o_full, o_count - full flag and occupancy
module result_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push_vld,
    input  logic [WIDTH-1:0]         i_push_dat,
    input  logic                     i_pop_rdy,
    output logic [WIDTH-1:0]         o_head_dat,
    output logic                     o_head_vld,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = i_push_vld && !w_full && !i_flush;
    assign w_pop   = i_pop_rdy && !w_empty && !i_flush;

    // Pointers are exactly log2(DEPTH) bits, so they wrap on their own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    assign o_head_vld = !w_empty;
    assign o_head_dat = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full     = w_full;
    assign o_count    = r_count;

endmodule

// File: rtl/result_drain.sv
// Captures four accumulator lanes, requantizes them and serializes lowest lane first.
// Latency: valid_in at cycle N reaches out_valid at cycle N+2 (empty FIFO, no other pending lane).
// Backpressure: full FIFO stalls the drain; a new sample on a still-waiting lane is dropped and sets overflow.
//
// Optional feature: define RESULT_DRAIN_RELU_EN to add input relu_en, which
// replaces negative saturated results with 0 before they enter the FIFO.
//
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   acc_in_0..acc_in_3  - signed accumulator lanes
//   valid_in            - per-lane capture strobe
//   cfg_shift           - requantization right shift (quasi-static)
//   flush               - synchronous clear of pending lanes, FIFO and overflow
//   relu_en             - (RESULT_DRAIN_RELU_EN only) clamp negatives to 0
//   res                 - valid/ready result port (data, lane, valid, ready)
//   overflow            - sticky lane-overrun flag
//   fifo_count          - output FIFO occupancy
//   busy                - any pending lane or non-empty FIFO
module result_drain
    import result_drain_pkg::*;
#(
    parameter int W          = RD_W,
    parameter int ACC_W      = RD_ACC_W,
    parameter int N_MACS     = RD_N_MACS,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [ACC_W-1:0]       acc_in_0,
    input  logic signed [ACC_W-1:0]       acc_in_1,
    input  logic signed [ACC_W-1:0]       acc_in_2,
    input  logic signed [ACC_W-1:0]       acc_in_3,
    input  logic [N_MACS-1:0]             valid_in,
    input  logic [$clog2(ACC_W)-1:0]      cfg_shift,
    input  logic                          flush,
`ifdef RESULT_DRAIN_RELU_EN
    input  logic                          relu_en,
`endif
    result_drain_if.master                res,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy
);

    logic signed [ACC_W-1:0] w_acc  [N_MACS];
    logic signed [ACC_W-1:0] r_hold [N_MACS];
    logic [N_MACS-1:0]       r_pend;
    logic                    r_ovf;

    lane_t                   w_sel;
    logic                    w_any_pend;
    logic                    w_drain;
    logic [N_MACS-1:0]       w_drain_oh;
    logic [N_MACS-1:0]       w_take;
    logic [N_MACS-1:0]       w_drop;
    res_t                    w_q;
    res_t                    w_res;
    fifo_entry_t             w_push_ent;
    fifo_entry_t             w_head_ent;
    logic                    w_head_vld;
    logic                    w_fifo_full;

    assign w_acc[0] = acc_in_0;
    assign w_acc[1] = acc_in_1;
    assign w_acc[2] = acc_in_2;
    assign w_acc[3] = acc_in_3;

    // Fixed-priority pick: scanning downward leaves the lowest pending lane.
    always_comb begin
        w_sel = '0;
        for (int i = N_MACS - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_sel = lane_t'(i);
            end
        end
    end

    assign w_any_pend = |r_pend;
    assign w_drain    = w_any_pend && !w_fifo_full && !flush;
    assign w_drain_oh = w_drain ? (N_MACS'(1) << w_sel) : '0;

    // A lane may take a new sample when it is free or is being drained this
    // cycle; the drain reads the old hold value since capture lands at the edge.
    assign w_take = valid_in & (~r_pend | w_drain_oh);
    assign w_drop = valid_in & r_pend & ~w_drain_oh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= '0;
            r_ovf  <= 1'b0;
            for (int i = 0; i < N_MACS; i++) begin
                r_hold[i] <= '0;
            end
        end else if (flush) begin
            r_pend <= '0;
            r_ovf  <= 1'b0;
        end else begin
            // A dropped sample leaves its lane pending, so OR-ing valid_in
            // in covers capture, re-capture during drain, and drop alike.
            r_pend <= (r_pend & ~w_drain_oh) | valid_in;
            if (|w_drop) begin
                r_ovf <= 1'b1;
            end
            for (int i = 0; i < N_MACS; i++) begin
                if (w_take[i]) begin
                    r_hold[i] <= w_acc[i];
                end
            end
        end
    end

    assign w_q = requant(r_hold[w_sel], cfg_shift);

`ifdef RESULT_DRAIN_RELU_EN
    assign w_res = (relu_en && w_q[W-1]) ? '0 : w_q;
`else
    assign w_res = w_q;
`endif

    assign w_push_ent.lane = w_sel;
    assign w_push_ent.data = w_res;

    result_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (flush),
        .i_push_vld (w_drain),
        .i_push_dat (w_push_ent),
        .i_pop_rdy  (res.out_ready),
        .o_head_dat (w_head_ent),
        .o_head_vld (w_head_vld),
        .o_full     (w_fifo_full),
        .o_count    (fifo_count)
    );

    assign res.out_data  = w_head_ent.data;
    assign res.out_lane  = w_head_ent.lane;
    assign res.out_valid = w_head_vld;

    assign overflow = r_ovf;
    assign busy     = w_any_pend || (fifo_count != '0);

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: vector table plus multi-cycle sequences.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Define RESULT_DRAIN_RELU_EN to also exercise the relu_en input.
module tb_result_drain;
    import result_drain_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] acc [4];
    logic [3:0]         valid_in;
    logic [3:0]         cfg_shift;
    logic               flush;
`ifdef RESULT_DRAIN_RELU_EN
    logic               relu_en;
`endif
    logic               overflow;
    logic [3:0]         fifo_count;
    logic               busy;

    result_drain_if #(.W(8)) res_if ();

    result_drain u_dut (
        .clk        (clk),
        .rst        (rst),
        .acc_in_0   (acc[0]),
        .acc_in_1   (acc[1]),
        .acc_in_2   (acc[2]),
        .acc_in_3   (acc[3]),
        .valid_in   (valid_in),
        .cfg_shift  (cfg_shift),
        .flush      (flush),
`ifdef RESULT_DRAIN_RELU_EN
        .relu_en    (relu_en),
`endif
        .res        (res_if),
        .overflow   (overflow),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One isolated sample: checks the N+1 / N+2 timing and the result.
    task automatic send_one(input int lane, input int val, input int shift,
                            input int exp_d, input string tag);
        cfg_shift = 4'(shift);
        acc[lane] = 16'(val);
        valid_in  = 4'(1 << lane);
        @(negedge clk);
        valid_in = '0;
        chk({tag, "_n1_valid"}, int'(res_if.out_valid), 0);
        @(negedge clk);
        chk({tag, "_valid"}, int'(res_if.out_valid), 1);
        chk({tag, "_data"}, int'(res_if.out_data), exp_d);
        chk({tag, "_lane"}, int'(res_if.out_lane), lane);
        @(negedge clk);
        chk({tag, "_idle"}, int'(busy), 0);
    endtask

    typedef struct {
        int lane;
        int acc;
        int shift;
        int exp_d;
    } vec_t;

    vec_t vt [16];
    int   exp_d [9];
    int   exp_l [9];
    int   idx;

    initial begin
        vt[0]  = '{0,    291,  4,   18};
        vt[1]  = '{1,   -300,  4,  -19};
        vt[2]  = '{1,  32767,  4,  127};
        vt[3]  = '{2, -32768,  4, -128};
        vt[4]  = '{3,      0,  4,    0};
        vt[5]  = '{0,      5,  0,    5};
        vt[6]  = '{0,    200,  0,  127};
        vt[7]  = '{2,   -129,  0, -128};
        vt[8]  = '{3,     24,  4,    2};
        vt[9]  = '{0,     23,  4,    1};
        vt[10] = '{0,     -8,  4,    0};
        vt[11] = '{0,     -9,  4,   -1};
        vt[12] = '{0,  32767, 15,    1};
        vt[13] = '{0, -32768, 15,   -1};
        vt[14] = '{1,   1000,  3,  125};
        vt[15] = '{3,    -24,  3,   -3};

        rst       = 1'b0;
        valid_in  = '0;
        cfg_shift = 4'd4;
        flush     = 1'b0;
        for (int i = 0; i < 4; i++) acc[i] = '0;
`ifdef RESULT_DRAIN_RELU_EN
        relu_en   = 1'b0;
`endif
        res_if.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid",    int'(res_if.out_valid), 0);
        chk("rst_count",    int'(fifo_count), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_busy",     int'(busy), 0);
        chk("rst_data",     int'(res_if.out_data), 0);
        chk("rst_lane",     int'(res_if.out_lane), 0);
        rst = 1'b1;
        @(negedge clk);

        // Requantization / latency table
        for (int i = 0; i < 16; i++) begin
            send_one(vt[i].lane, vt[i].acc, vt[i].shift, vt[i].exp_d,
                     $sformatf("vec%0d", i));
        end

        // All four lanes at once: drained lowest first, one per cycle
        cfg_shift = 4'd4;
        acc[0] = -16'sd300;
        acc[1] = 16'sd32767;
        acc[2] = -16'sd32768;
        acc[3] = 16'sd0;
        valid_in = 4'b1111;
        @(negedge clk);
        valid_in = '0;
        @(negedge clk);
        exp_d[0] = -19; exp_d[1] = 127; exp_d[2] = -128; exp_d[3] = 0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("all_valid%0d", k), int'(res_if.out_valid), 1);
            chk($sformatf("all_lane%0d", k),  int'(res_if.out_lane), k);
            chk($sformatf("all_data%0d", k),  int'(res_if.out_data), exp_d[k]);
            @(negedge clk);
        end
        chk("all_done_valid", int'(res_if.out_valid), 0);

        // Same-lane drain and re-capture
        acc[2]   = 16'sd160;
        valid_in = 4'b0100;
        @(negedge clk);
        acc[2]   = 16'sd320;
        valid_in = 4'b0100;
        @(negedge clk);
        valid_in = '0;
        chk("same_first_valid", int'(res_if.out_valid), 1);
        chk("same_first_data",  int'(res_if.out_data), 10);
        chk("same_first_lane",  int'(res_if.out_lane), 2);
        @(negedge clk);
        chk("same_second_valid", int'(res_if.out_valid), 1);
        chk("same_second_data",  int'(res_if.out_data), 20);
        chk("same_second_lane",  int'(res_if.out_lane), 2);
        chk("same_overflow",     int'(overflow), 0);
        @(negedge clk);
        chk("same_idle", int'(busy), 0);

        // Backpressure: fill FIFO, hold one lane, overrun it, then drain
        res_if.out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            acc[k % 4] = 16'(k * 16);
            valid_in   = 4'(1 << (k % 4));
            exp_d[k]   = k;
            exp_l[k]   = k % 4;
            @(negedge clk);
        end
        valid_in = '0;
        @(negedge clk);
        chk("bp_count_full", int'(fifo_count), 8);
        chk("bp_no_ovf_yet", int'(overflow), 0);
        acc[0]   = 16'sd144;
        valid_in = 4'b0001;
        exp_d[8] = 9;
        exp_l[8] = 0;
        @(negedge clk);
        chk("bp_held_count", int'(fifo_count), 8);
        chk("bp_held_busy",  int'(busy), 1);
        chk("bp_held_ovf",   int'(overflow), 0);
        acc[0]   = 16'sd160;
        valid_in = 4'b0001;
        @(negedge clk);
        valid_in = '0;
        chk("bp_overrun_ovf", int'(overflow), 1);
        res_if.out_ready = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 40 && idx < 9; cyc++) begin
            if (res_if.out_valid) begin
                chk($sformatf("bp_lane%0d", idx), int'(res_if.out_lane), exp_l[idx]);
                chk($sformatf("bp_data%0d", idx), int'(res_if.out_data), exp_d[idx]);
                idx++;
            end
            @(negedge clk);
        end
        chk("bp_drained_all", idx, 9);
        chk("bp_after_busy",  int'(busy), 0);
        chk("bp_ovf_sticky",  int'(overflow), 1);

        // Flush with 3 queued entries and 2 pending lanes (overflow still set)
        res_if.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            acc[0]   = 16'(k * 16);
            valid_in = 4'b0001;
            @(negedge clk);
        end
        acc[1]   = 16'sd100;
        acc[2]   = 16'sd200;
        valid_in = 4'b0110;
        @(negedge clk);
        chk("fl_pre_count", int'(fifo_count), 3);
        chk("fl_pre_busy",  int'(busy), 1);
        chk("fl_pre_ovf",   int'(overflow), 1);
        flush    = 1'b1;
        acc[3]   = 16'sd50;
        valid_in = 4'b1000;
        @(negedge clk);
        flush    = 1'b0;
        valid_in = '0;
        chk("fl_count", int'(fifo_count), 0);
        chk("fl_busy",  int'(busy), 0);
        chk("fl_ovf",   int'(overflow), 0);
        chk("fl_valid", int'(res_if.out_valid), 0);
        @(negedge clk);
        chk("fl_no_capture", int'(busy), 0);

        // Reset in the middle of a transfer discards the sample
        res_if.out_ready = 1'b1;
        acc[0]   = 16'sd16;
        valid_in = 4'b0001;
        @(negedge clk);
        valid_in = '0;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_busy",  int'(busy), 0);
        chk("mid_rst_valid", int'(res_if.out_valid), 0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("mid_rst_quiet%0d", k), int'(res_if.out_valid), 0);
        end

`ifdef RESULT_DRAIN_RELU_EN
        relu_en = 1'b1;
        send_one(1, -300, 4, 0, "relu_on");
        send_one(1, 291, 4, 18, "relu_pos");
        relu_en = 1'b0;
        send_one(1, -300, 4, -19, "relu_off");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
